usb_bus_scheduler: RTL and testbench

//  Sequences the shared 32-bit synchronous FT245-style USB bus between the RX direction
//  (USB -> rx FIFO) and the TX direction (tx FIFO -> USB), in the usb_clk domain.

---
 rtl/usb_bus_scheduler.sv | 122 ++++++++++++
 tb/tb_usb_bus_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_bus_scheduler.sv
// usb_bus_scheduler
// Arbitrates the shared synchronous FT245-style USB bus between the RX direction
// (device -> rx FIFO) and the TX direction (tx FIFO -> device). Round-robin on ties,
// bursts capped at BURST_MAX words, and a guard cycle on every burst exit so the
// device has released the data bus before the FPGA starts driving it.
//
// Handshake: a word moves only on a "beat", i.e. a cycle where the FPGA strobe is
// active (usb_rd=0 in RX_BURST, usb_wr=0 in TX_BURST) and the device flag is low
// in the same cycle (usb_rxf=0 for RX, usb_txe=0 for TX). The FIFO strobes
// rx_fifo_write / tx_fifo_read are exactly these beats, so the FIFO side sees one
// push/pop per transferred word and nothing else.
module usb_bus_scheduler #(
    parameter int BURST_MAX = 256,
    parameter int CNT_W     = 32
) (
    input  logic             usb_clk,
    input  logic             rst,
    input  logic             usb_rxf,
    input  logic             usb_txe,
    input  logic             tx_fifo_prog_empty,
    input  logic             rx_fifo_prog_full,
    output logic             usb_oe,
    output logic             usb_rd,
    output logic             usb_wr,
    output logic             bus_drive,
    output logic             tx_fifo_read,
    output logic             rx_fifo_write,
    output logic             dir_rx,
    output logic [CNT_W-1:0] rx_word_cnt,
    output logic [CNT_W-1:0] tx_word_cnt,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RX_OE    = 3'd1,
        RX_BURST = 3'd2,
        RX_END   = 3'd3,
        TX_BURST = 3'd4,
        TX_END   = 3'd5
    } state_t;

    // Beat index at which a burst is cut short and the bus re-arbitrated.
    localparam logic [15:0] BURST_LAST = 16'(BURST_MAX - 1);

    state_t      state;
    logic        last_rx;
    logic [15:0] burst_cnt;

    logic rx_req;
    logic tx_req;
    logic rx_beat;
    logic tx_beat;
    logic burst_full;

    // Request, beat and burst-cap terms; beats are masked during reset so a
    // reset cycle neither strobes a FIFO nor counts a word.
    always_comb begin
        rx_req     = !usb_rxf && !rx_fifo_prog_full;
        tx_req     = !usb_txe && !tx_fifo_prog_empty;
        rx_beat    = (state == RX_BURST) && !usb_rxf && !rst;
        tx_beat    = (state == TX_BURST) && !usb_txe && !rst;
        burst_full = (burst_cnt == BURST_LAST);
    end

    // Bus and FIFO strobes decoded from the state register (plus the beat terms).
    always_comb begin
        usb_oe        = !((state == RX_OE) || (state == RX_BURST));
        usb_rd        = !(state == RX_BURST);
        usb_wr        = !(state == TX_BURST);
        bus_drive     = (state == TX_BURST);
        dir_rx        = (state == RX_OE) || (state == RX_BURST);
        rx_fifo_write = rx_beat;
        tx_fifo_read  = tx_beat;
        state_dbg     = state;
    end

    // Scheduler FSM with the round-robin memory, burst length and word counters.
    always_ff @(posedge usb_clk) begin
        if (rst) begin
            state       <= IDLE;
            last_rx     <= 1'b0;
            burst_cnt   <= 16'd0;
            rx_word_cnt <= '0;
            tx_word_cnt <= '0;
        end else begin
            if (rx_beat) rx_word_cnt <= rx_word_cnt + CNT_W'(1);
            if (tx_beat) tx_word_cnt <= tx_word_cnt + CNT_W'(1);

            case (state)
                IDLE: begin
                    burst_cnt <= 16'd0;
                    // On a tie, grant the direction that did not have the last burst.
                    if (rx_req && (!tx_req || !last_rx)) begin
                        state   <= RX_OE;
                        last_rx <= 1'b1;
                    end else if (tx_req) begin
                        state   <= TX_BURST;
                        last_rx <= 1'b0;
                    end
                end
                // One cycle with usb_oe low before usb_rd so the device turns the bus around.
                RX_OE: state <= RX_BURST;
                RX_BURST: begin
                    if (rx_beat) burst_cnt <= burst_cnt + 16'd1;
                    if (usb_rxf || rx_fifo_prog_full || (rx_beat && burst_full))
                        state <= RX_END;
                end
                // RX_END plus IDLE give two released cycles before any TX drive.
                RX_END: state <= IDLE;
                TX_BURST: begin
                    if (tx_beat) burst_cnt <= burst_cnt + 16'd1;
                    if (usb_txe || tx_fifo_prog_empty || (tx_beat && burst_full))
                        state <= TX_END;
                end
                TX_END:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_bus_scheduler.sv
// tb_usb_bus_scheduler
// Drives usb_bus_scheduler (BURST_MAX=4, CNT_W=8) through single bursts, round-robin
// alternation, early burst exits, mid-burst reset and counter wrap. Expected beats
// are queued per scenario and consumed by the monitor whenever a FIFO strobe fires.
module tb_usb_bus_scheduler;

    localparam int BURST_MAX = 4;
    localparam int CNT_W     = 8;
    localparam int W         = 7;

    // Beat signature: {tx_fifo_read, rx_fifo_write, bus_drive, usb_oe, usb_rd, usb_wr, dir_rx}
    localparam logic [W-1:0] EV_RX = 7'b0100011;
    localparam logic [W-1:0] EV_TX = 7'b1011100;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_RX_OE    = 3'd1;
    localparam logic [2:0] S_RX_BURST = 3'd2;
    localparam logic [2:0] S_RX_END   = 3'd3;
    localparam logic [2:0] S_TX_BURST = 3'd4;
    localparam logic [2:0] S_TX_END   = 3'd5;

    logic             usb_clk;
    logic             rst;
    logic             usb_rxf;
    logic             usb_txe;
    logic             tx_fifo_prog_empty;
    logic             rx_fifo_prog_full;
    logic             usb_oe;
    logic             usb_rd;
    logic             usb_wr;
    logic             bus_drive;
    logic             tx_fifo_read;
    logic             rx_fifo_write;
    logic             dir_rx;
    logic [CNT_W-1:0] rx_word_cnt;
    logic [CNT_W-1:0] tx_word_cnt;
    logic [2:0]       state_dbg;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs;
    logic [W-1:0] exp_ev;
    int  oe_idle = 100;
    logic prev_drive = 1'b0;
    logic started = 1'b0;

    usb_bus_scheduler #(.BURST_MAX(BURST_MAX), .CNT_W(CNT_W)) dut (
        .usb_clk            (usb_clk),
        .rst                (rst),
        .usb_rxf            (usb_rxf),
        .usb_txe            (usb_txe),
        .tx_fifo_prog_empty (tx_fifo_prog_empty),
        .rx_fifo_prog_full  (rx_fifo_prog_full),
        .usb_oe             (usb_oe),
        .usb_rd             (usb_rd),
        .usb_wr             (usb_wr),
        .bus_drive          (bus_drive),
        .tx_fifo_read       (tx_fifo_read),
        .rx_fifo_write      (rx_fifo_write),
        .dir_rx             (dir_rx),
        .rx_word_cnt        (rx_word_cnt),
        .tx_word_cnt        (tx_word_cnt),
        .state_dbg          (state_dbg)
    );

    // Clock / reset block
    initial usb_clk = 1'b0;
    always #5 usb_clk = ~usb_clk;

    // Monitor: scoreboard pop on every FIFO strobe plus bus invariants each cycle
    always @(negedge usb_clk) begin
        if (started && !rst) begin
            if (rx_fifo_write || tx_fifo_read) begin
                obs = {tx_fifo_read, rx_fifo_write, bus_drive, usb_oe, usb_rd, usb_wr, dir_rx};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL beat_unexpected got=%b required=no beat", obs);
                end else begin
                    exp_ev = exp_q.pop_front();
                    if (obs !== exp_ev) begin
                        bad++;
                        $display("FAIL beat_signature got=%b required=%b", obs, exp_ev);
                    end
                end
            end
            total++;
            if (bus_drive && !usb_oe) begin
                bad++;
                $display("FAIL oe_drive_overlap got=drive1_oe0 required=never");
            end
            total++;
            if (!usb_rd && !usb_wr) begin
                bad++;
                $display("FAIL rd_wr_overlap got=rd0_wr0 required=never");
            end
            total++;
            if (bus_drive !== !usb_wr) begin
                bad++;
                $display("FAIL drive_vs_wr got=drive%0b_wr%0b required=drive only with wr low", bus_drive, usb_wr);
            end
            if (bus_drive && !prev_drive) begin
                total++;
                if (oe_idle < 2) begin
                    bad++;
                    $display("FAIL turnaround got=%0d required>=2", oe_idle);
                end
            end
            if (!usb_oe) oe_idle = 0;
            else if (!bus_drive && oe_idle < 100) oe_idle++;
            prev_drive = bus_drive;
        end
    end

    // Driver tasks
    task automatic cyc();
        @(posedge usb_clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        usb_rxf = 1'b1;
        usb_txe = 1'b1;
        tx_fifo_prog_empty = 1'b1;
        rx_fifo_prog_full = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        started = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        usb_rxf = 1'b0;
        usb_txe = 1'b0;
        tx_fifo_prog_empty = 1'b0;
        rx_fifo_prog_full = 1'b0;
        cyc();
        cyc();
        @(negedge usb_clk);
        total++; if (state_dbg !== S_IDLE) begin bad++; $display("FAIL reset_state got=%0d required=%0d", state_dbg, S_IDLE); end
        total++; if ({usb_oe, usb_rd, usb_wr} !== 3'b111) begin bad++; $display("FAIL reset_strobes got=%b required=111", {usb_oe, usb_rd, usb_wr}); end
        total++; if ({bus_drive, tx_fifo_read, rx_fifo_write, dir_rx} !== 4'b0000) begin bad++; $display("FAIL reset_drive got=%b required=0000", {bus_drive, tx_fifo_read, rx_fifo_write, dir_rx}); end
        total++; if (rx_word_cnt !== 8'd0) begin bad++; $display("FAIL reset_rx_cnt got=%0d required=0", rx_word_cnt); end
        total++; if (tx_word_cnt !== 8'd0) begin bad++; $display("FAIL reset_tx_cnt got=%0d required=0", tx_word_cnt); end
        do_reset();
    endtask

    // Single RX burst capped at BURST_MAX
    task automatic test_rx_burst();
        do_reset();
        for (int i = 0; i < BURST_MAX; i++) exp_q.push_back(EV_RX);
        usb_rxf = 1'b0;
        @(negedge usb_clk);
        total++; if (state_dbg !== S_IDLE) begin bad++; $display("FAIL rx1_idle got=%0d required=%0d", state_dbg, S_IDLE); end
        cyc();
        @(negedge usb_clk);
        total++; if ({state_dbg, usb_oe, usb_rd} !== {S_RX_OE, 2'b01}) begin bad++; $display("FAIL rx1_oe got=%b required=%b", {state_dbg, usb_oe, usb_rd}, {S_RX_OE, 2'b01}); end
        cyc();
        @(negedge usb_clk);
        total++; if ({state_dbg, usb_rd, rx_fifo_write} !== {S_RX_BURST, 2'b01}) begin bad++; $display("FAIL rx1_burst got=%b required=%b", {state_dbg, usb_rd, rx_fifo_write}, {S_RX_BURST, 2'b01}); end
        for (int n = 0; n < 10; n++) begin
            cyc();
            @(negedge usb_clk);
            if (state_dbg == S_RX_END) break;
        end
        total++; if ({state_dbg, usb_rd, rx_fifo_write} !== {S_RX_END, 2'b10}) begin bad++; $display("FAIL rx1_end got=%b required=%b", {state_dbg, usb_rd, rx_fifo_write}, {S_RX_END, 2'b10}); end
        total++; if (rx_word_cnt !== 8'd4) begin bad++; $display("FAIL rx1_count got=%0d required=4", rx_word_cnt); end
        cyc();
        usb_rxf = 1'b1;
        @(negedge usb_clk);
        total++; if (state_dbg !== S_IDLE) begin bad++; $display("FAIL rx1_back_idle got=%0d required=%0d", state_dbg, S_IDLE); end
        cyc();
        @(negedge usb_clk);
        #1;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rx1_queue got=%0d required=0", exp_q.size()); end
    endtask

    // Both directions requesting: RX, TX, RX, TX of BURST_MAX words each
    task automatic test_back_to_back();
        do_reset();
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < BURST_MAX; i++) exp_q.push_back((b % 2 == 0) ? EV_RX : EV_TX);
        usb_rxf = 1'b0;
        usb_txe = 1'b0;
        tx_fifo_prog_empty = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge usb_clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_timeout got=%0d left required=0", exp_q.size()); end
        cyc();
        usb_rxf = 1'b1;
        usb_txe = 1'b1;
        tx_fifo_prog_empty = 1'b1;
        @(negedge usb_clk);
        total++; if ({state_dbg, usb_wr, bus_drive} !== {S_TX_END, 2'b10}) begin bad++; $display("FAIL b2b_tx_end got=%b required=%b", {state_dbg, usb_wr, bus_drive}, {S_TX_END, 2'b10}); end
        total++; if (rx_word_cnt !== 8'd8) begin bad++; $display("FAIL b2b_rx_cnt got=%0d required=8", rx_word_cnt); end
        total++; if (tx_word_cnt !== 8'd8) begin bad++; $display("FAIL b2b_tx_cnt got=%0d required=8", tx_word_cnt); end
        cyc();
    endtask

    // TX burst ended early by usb_txe after 3 beats
    task automatic test_tx_early_stop();
        do_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back(EV_TX);
        usb_txe = 1'b0;
        tx_fifo_prog_empty = 1'b0;
        cyc();
        for (int i = 0; i < 3; i++) begin
            @(negedge usb_clk);
            total++; if (tx_fifo_read !== 1'b1) begin bad++; $display("FAIL tx3_beat%0d got=%b required=1", i, tx_fifo_read); end
            cyc();
        end
        usb_txe = 1'b1;
        @(negedge usb_clk);
        total++; if ({state_dbg, tx_fifo_read} !== {S_TX_BURST, 1'b0}) begin bad++; $display("FAIL tx3_stall got=%b required=%b", {state_dbg, tx_fifo_read}, {S_TX_BURST, 1'b0}); end
        total++; if (tx_word_cnt !== 8'd3) begin bad++; $display("FAIL tx3_count got=%0d required=3", tx_word_cnt); end
        cyc();
        @(negedge usb_clk);
        total++; if ({state_dbg, usb_wr, bus_drive} !== {S_TX_END, 2'b10}) begin bad++; $display("FAIL tx3_end got=%b required=%b", {state_dbg, usb_wr, bus_drive}, {S_TX_END, 2'b10}); end
        tx_fifo_prog_empty = 1'b1;
        cyc();
        @(negedge usb_clk);
        #1;
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL tx3_queue got=%0d required=0", exp_q.size()); end
    endtask

    // rx FIFO fills on beat 2: beat still written, RX held off until it drains
    task automatic test_rx_prog_full();
        do_reset();
        for (int i = 0; i < 2; i++) exp_q.push_back(EV_RX);
        usb_rxf = 1'b0;
        cyc();
        cyc();
        @(negedge usb_clk);
        total++; if (rx_fifo_write !== 1'b1) begin bad++; $display("FAIL full_beat1 got=%b required=1", rx_fifo_write); end
        cyc();
        rx_fifo_prog_full = 1'b1;
        @(negedge usb_clk);
        total++; if ({state_dbg, rx_fifo_write} !== {S_RX_BURST, 1'b1}) begin bad++; $display("FAIL full_beat2 got=%b required=%b", {state_dbg, rx_fifo_write}, {S_RX_BURST, 1'b1}); end
        cyc();
        @(negedge usb_clk);
        total++; if ({state_dbg, usb_rd} !== {S_RX_END, 1'b1}) begin bad++; $display("FAIL full_release got=%b required=%b", {state_dbg, usb_rd}, {S_RX_END, 1'b1}); end
        total++; if (rx_word_cnt !== 8'd2) begin bad++; $display("FAIL full_count got=%0d required=2", rx_word_cnt); end
        for (int n = 0; n < 5; n++) begin
            cyc();
            @(negedge usb_clk);
            total++; if (usb_oe !== 1'b1) begin bad++; $display("FAIL full_hold%0d got=oe%b required=oe1", n, usb_oe); end
        end
        rx_fifo_prog_full = 1'b0;
        cyc();
        @(negedge usb_clk);
        total++; if ({state_dbg, usb_oe} !== {S_RX_OE, 1'b0}) begin bad++; $display("FAIL full_regrant got=%b required=%b", {state_dbg, usb_oe}, {S_RX_OE, 1'b0}); end
        usb_rxf = 1'b1;
        cyc();
        cyc();
        cyc();
        @(negedge usb_clk);
        #1;
        total++; if ({state_dbg, rx_word_cnt} !== {S_IDLE, 8'd2}) begin bad++; $display("FAIL full_tail got=%b required=%b", {state_dbg, rx_word_cnt}, {S_IDLE, 8'd2}); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL full_queue got=%0d required=0", exp_q.size()); end
    endtask

    // Reset lands in the middle of a TX burst
    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 2; i++) exp_q.push_back(EV_TX);
        usb_txe = 1'b0;
        tx_fifo_prog_empty = 1'b0;
        cyc();
        @(negedge usb_clk);
        cyc();
        @(negedge usb_clk);
        cyc();
        rst = 1'b1;
        @(negedge usb_clk);
        total++; if (tx_word_cnt !== 8'd2) begin bad++; $display("FAIL mrst_before got=%0d required=2", tx_word_cnt); end
        cyc();
        @(negedge usb_clk);
        total++; if ({usb_wr, bus_drive} !== 2'b10) begin bad++; $display("FAIL mrst_bus got=%b required=10", {usb_wr, bus_drive}); end
        total++; if ({tx_word_cnt, rx_word_cnt} !== 16'd0) begin bad++; $display("FAIL mrst_cnt got=%0d/%0d required=0/0", tx_word_cnt, rx_word_cnt); end
        total++; if (state_dbg !== S_IDLE) begin bad++; $display("FAIL mrst_state got=%0d required=%0d", state_dbg, S_IDLE); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL mrst_queue got=%0d required=0", exp_q.size()); end
        do_reset();
    endtask

    // Enough RX words to roll the 8-bit counter past zero
    task automatic test_cnt_wrap();
        int words;
        do_reset();
        words = BURST_MAX * ($urandom_range(65, 68));
        for (int i = 0; i < words; i++) exp_q.push_back(EV_RX);
        usb_rxf = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge usb_clk);
            #1;
            if (exp_q.size() == 0) break;
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_timeout got=%0d left required=0", exp_q.size()); end
        cyc();
        usb_rxf = 1'b1;
        @(negedge usb_clk);
        total++; if (rx_word_cnt !== 8'(words % 256)) begin bad++; $display("FAIL wrap_count got=%0d required=%0d", rx_word_cnt, words % 256); end
        total++; if (state_dbg !== S_RX_END) begin bad++; $display("FAIL wrap_end got=%0d required=%0d", state_dbg, S_RX_END); end
        cyc();
        cyc();
    endtask

    initial begin
        rst = 1'b1;
        usb_rxf = 1'b1;
        usb_txe = 1'b1;
        tx_fifo_prog_empty = 1'b1;
        rx_fifo_prog_full = 1'b0;
        test_reset();
        test_rx_burst();
        test_back_to_back();
        test_tx_early_stop();
        test_rx_prog_full();
        test_mid_reset();
        test_cnt_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
